// File: rtl/hazard_stall_ctrl_if.sv
// hazard_stall_ctrl_if: hazard inputs and pipeline control outputs of the stall controller
interface hazard_stall_ctrl_if #(parameter int CNT_W = 16);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic [4:0]       idex_rt;
    logic             idex_memread;
    logic             exmem_memread;
    logic             exmem_memwrite;
    logic [1:0]       exmem_pcsrc;
    logic             mem_ready;
    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic             memwb_flush;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs, id_rt, idex_rt, idex_memread, exmem_memread, exmem_memwrite,
               exmem_pcsrc, mem_ready,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
               exmem_flush, memwb_flush, mem_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs, id_rt, idex_rt, idex_memread, exmem_memread, exmem_memwrite,
               exmem_pcsrc, mem_ready,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
               exmem_flush, memwb_flush, mem_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: 5-stage pipeline stall/flush sequencing with memory-timeout halt and perf counters
module hazard_stall_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input logic              clk,
    input logic              rst,
    hazard_stall_ctrl_if.slave bus
);
    localparam int MW = (MAX_WAIT < 2) ? 2 : MAX_WAIT;
    localparam int WW = $clog2(MW);

    typedef enum logic [1:0] {S_RUN, S_WAIT, S_ERR} state_t;

    state_t           state_q, state_d;
    logic [WW-1:0]    wcnt_q, wcnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             mem_busy, load_use, redirect, halted, stall_inc, flush_inc;

    assign mem_busy  = (bus.exmem_memread | bus.exmem_memwrite) & ~bus.mem_ready;
    assign load_use  = bus.idex_memread & (bus.idex_rt != 5'd0) &
                       ((bus.idex_rt == bus.id_rs) | (bus.idex_rt == bus.id_rt));
    assign redirect  = bus.exmem_pcsrc != 2'b00;
    assign halted    = rst | (state_q == S_ERR);
    assign stall_inc = ~halted & (mem_busy | (~redirect & load_use));
    assign flush_inc = ~halted & ~mem_busy & redirect;

    // State, wait counter and performance counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_RUN;
            wcnt_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Memory-wait FSM: count wait cycles, halt once the tolerance is exhausted
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            S_RUN: begin
                if (mem_busy) begin
                    state_d = S_WAIT;
                    wcnt_d  = WW'(1);
                end
            end
            S_WAIT: begin
                if (bus.mem_ready) begin
                    state_d = S_RUN;
                    wcnt_d  = '0;
                end else if (wcnt_q == WW'(MW - 1)) begin
                    state_d = S_ERR;
                end else begin
                    wcnt_d = wcnt_q + WW'(1);
                end
            end
            default: state_d = S_ERR;
        endcase
    end

    // Saturating counter next-state
    always_comb begin
        stall_cnt_d = (stall_inc && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
        flush_cnt_d = (flush_inc && !(&flush_cnt_q)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
    end

    // Pipeline controls, highest priority first: halt, memory stall, redirect, load-use
    always_comb begin
        bus.pc_en       = 1'b1;
        bus.ifid_en     = 1'b1;
        bus.idex_en     = 1'b1;
        bus.exmem_en    = 1'b1;
        bus.memwb_en    = 1'b1;
        bus.ifid_flush  = 1'b0;
        bus.idex_flush  = 1'b0;
        bus.exmem_flush = 1'b0;
        bus.memwb_flush = 1'b0;
        if (halted) begin
            bus.pc_en    = 1'b0;
            bus.ifid_en  = 1'b0;
            bus.idex_en  = 1'b0;
            bus.exmem_en = 1'b0;
            bus.memwb_en = 1'b0;
        end else if (mem_busy) begin
            bus.pc_en       = 1'b0;
            bus.ifid_en     = 1'b0;
            bus.idex_en     = 1'b0;
            bus.exmem_en    = 1'b0;
            bus.memwb_flush = 1'b1;
        end else if (redirect) begin
            bus.ifid_flush  = 1'b1;
            bus.idex_flush  = 1'b1;
            bus.exmem_flush = 1'b1;
        end else if (load_use) begin
            bus.pc_en      = 1'b0;
            bus.ifid_en    = 1'b0;
            bus.idex_flush = 1'b1;
        end
    end

    assign bus.mem_err   = state_q == S_ERR;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Pipeline sequencing controller for the 5-stage MIPS datapath. It generates the enable and flush controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves load-use hazards, branch/jump redirects resolved in MEM, and multi-cycle data-memory waits, and it keeps saturating stall/flush performance counters.

Parameters:
MAX_WAIT, 16, memory-wait cycles tolerated before the error halt (must be >=2)
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  reset, asynchronous, active-high
id_rs  in  5  rs field of the instruction in ID
id_rt  in  5  rt field of the instruction in ID
idex_rt  in  5  destination rt of the instruction in EX
idex_memread  in  1  instruction in EX is a load
exmem_memread  in  1  MemRead of the instruction in MEM
exmem_memwrite  in  1  MemWrite of the instruction in MEM
exmem_pcsrc  in  2  PCSrc of the instruction in MEM; 00 = sequential, any other value = redirect
mem_ready  in  1  data memory completes the access this cycle
pc_en  out  1  PC load enable
ifid_en, idex_en, exmem_en, memwb_en  out  1 each  pipeline register load enables
ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  load a bubble (all-zero control) at the next edge
mem_err  out  1  sticky memory-timeout error
stall_cnt  out  CNT_W  cycles stalled (saturating)
flush_cnt  out  CNT_W  redirects taken (saturating)

Behaviour:
- Internal signals:
  - mem_busy = (exmem_memread | exmem_memwrite) & ~mem_ready
  - load_use = idex_memread & (idex_rt != 0) & ((idex_rt == id_rs) | (idex_rt == id_rt))
  - redirect = (exmem_pcsrc != 2'b00)
- FSM states are RUN, WAIT and ERR. An internal wait counter wcnt is clog2(MAX_WAIT) bits wide.
  - RUN: if mem_busy, go to WAIT with wcnt=1; otherwise stay.
  - WAIT: if mem_ready, go to RUN. Otherwise, if wcnt == MAX_WAIT-1, go to ERR; else wcnt++.
  - ERR: terminal; only rst leaves it. mem_err=1 in ERR.
- Outputs are combinational from state and inputs. Priority is highest first; defaults are all enables 1 and all flushes 0.
  1. rst asserted or state ERR: all enables 0, all flushes 0.
  2. mem_busy (in RUN or WAIT): pc_en, ifid_en, idex_en and exmem_en are 0; memwb_flush=1 (bubble into WB); memwb_en=1.
  3. redirect: pc_en=1 (target load); ifid_flush, idex_flush and exmem_flush are 1. The redirecting instruction advances to WB normally.
  4. load_use: pc_en=0, ifid_en=0, idex_flush=1. EX/MEM and MEM/WB advance.
- Simultaneous events:
  - mem_busy with redirect: the stall wins and the redirect is re-evaluated when mem_ready rises, because EX/MEM holds its value.
  - redirect with load_use: the redirect wins and the load-use stall is not counted.
  - mem_ready=1 on the first access cycle: no stall and no state change.
- Latency: the memory stall is visible the same cycle mem_busy rises. The load-use stall lasts exactly 1 cycle, since the bubble clears idex_memread.
- Counters:
  - stall_cnt increments in each cycle where case 2 or case 4 is the active action (not ERR).
  - flush_cnt increments in each cycle where case 3 is active.
  - Both saturate at all-ones.
- Reset values: state RUN, wcnt 0, mem_err 0, stall_cnt 0, flush_cnt 0. Reset mid-WAIT or in ERR returns to RUN immediately (asynchronous).
- A disallowed MAX_WAIT (<2) is clamped to 2.

Test Plan:
- Load-use: idex_memread=1, idex_rt=5, id_rs=5 for one cycle -> pc_en=0, ifid_en=0, idex_flush=1 for exactly that cycle; stall_cnt 0->1. Repeat with idex_rt=0 -> no stall.
- Memory wait: exmem_memread=1, mem_ready=0 for 3 cycles then 1 -> pc/ifid/idex/exmem_en=0 and memwb_flush=1 for 3 cycles; state WAIT then RUN; stall_cnt=3; mem_ready=1 on cycle 1 gives 0 stalls.
- Redirect: exmem_pcsrc=2'b01 for one cycle -> pc_en=1, ifid/idex/exmem_flush=1; flush_cnt=1. Same cycle with load_use=1 -> flushes only, stall_cnt unchanged.
- Timeout: MAX_WAIT=4, exmem_memwrite=1, mem_ready held 0 -> ERR entered at the 4th edge; mem_err=1, all enables 0; later mem_ready=1 has no effect; asserting rst clears to RUN with mem_err=0 and counters 0.
- Busy with redirect: exmem_pcsrc=2'b10, exmem_memread=1, mem_ready=0 for 2 cycles then 1 -> stall 2 cycles, then the redirect flush in the mem_ready cycle; flush_cnt=1, stall_cnt=2.
- Saturation: CNT_W=4, 20 consecutive load-use cycles -> stall_cnt stops at 15.
